// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose: shared types and helpers for the serial adder slice of the tile.
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - cntWidth  : width of the digit counter, clog2(WIDTH/DIGIT), at least 1
//
// Ports: none (package).
// Optional feature macro used elsewhere in this block: SERIAL_ADDER_SUB_EN.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit configuration (DIGIT == WIDTH) still needs a one-bit
    // counter so the counter declaration never collapses to zero width.
    function automatic int cntWidth(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_fsm_if.sv
// ---------------------------------------------------------------------------
// serial_adder_fsm_if
//
// Purpose: groups the start/busy/done handshake and the operand/result bus
// of serial_adder_fsm into one bundle.
//
// Signals:
//   start_i  request a new operation (sampled by the adder only in IDLE)
//   a_i      operand A, WIDTH bits
//   b_i      operand B, WIDTH bits
//   cin_i    carry-in
//   sub_i    subtract request (only when SERIAL_ADDER_SUB_EN is defined)
//   busy_o   high while the adder is running
//   done_o   one-cycle pulse when a new result is valid
//   sum_o    registered result, WIDTH bits
//   cout_o   registered carry-out
//
// Modports: master (requester side), slave (the adder).
// Optional feature macro: SERIAL_ADDER_SUB_EN adds sub_i.
// ---------------------------------------------------------------------------
interface serial_adder_fsm_if #(
    parameter int WIDTH = 8
);

    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_i;
`endif
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start_i, a_i, b_i, cin_i, sub_i,
        input  busy_o, done_o, sum_o, cout_o
    );

    modport slave (
        input  start_i, a_i, b_i, cin_i, sub_i,
        output busy_o, done_o, sum_o, cout_o
    );
`else
    modport master (
        output start_i, a_i, b_i, cin_i,
        input  busy_o, done_o, sum_o, cout_o
    );

    modport slave (
        input  start_i, a_i, b_i, cin_i,
        output busy_o, done_o, sum_o, cout_o
    );
`endif

endinterface

// File: rtl/serial_adder_slice.sv
// ---------------------------------------------------------------------------
// serial_adder_slice
//
// Purpose: combinational DIGIT-bit ripple adder. Each bit position is a pair
// of half adders (a^b, then that propagate term with the incoming carry),
// with the two half-adder carries ORed into the next position.
//
// Ports:
//   a     input  DIGIT  addend digit
//   b     input  DIGIT  addend digit
//   cin   input  1      carry into bit 0
//   s     output DIGIT  sum digit
//   cout  output 1      carry out of the top bit
// ---------------------------------------------------------------------------
module serial_adder_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    // Ripple the carry through the digit with a running variable rather than
    // a carry vector, so the chain reads as one sequential evaluation.
    always_comb begin
        logic w_carry;
        logic w_prop;
        logic w_gen;
        s       = '0;
        w_carry = cin;
        w_prop  = 1'b0;
        w_gen   = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            w_prop  = a[i] ^ b[i];
            w_gen   = a[i] & b[i];
            s[i]    = w_prop ^ w_carry;
            w_carry = w_gen | (w_prop & w_carry);
        end
        cout = w_carry;
    end

endmodule

// File: rtl/serial_adder_fsm.sv
// ---------------------------------------------------------------------------
// serial_adder_fsm
//
// Purpose: multi-cycle adder that processes DIGIT bits per clock, LSB first,
// using one serial_adder_slice and a registered carry. A start accepted in
// IDLE captures the operands; N = WIDTH/DIGIT RUN cycles later the result is
// loaded into sum_o/cout_o and done_o pulses for one cycle.
//
// Ports:
//   clk    input  1   system clock, rising edge
//   rst_n  input  1   asynchronous active-low reset
//   bus    serial_adder_fsm_if.slave  handshake, operands and result
//
// Parameters: WIDTH (>= 2), DIGIT (WIDTH must be a multiple of DIGIT).
// Optional feature macro: SERIAL_ADDER_SUB_EN -- when defined, sub_i=1
// captures ~B and forces the initial carry to 1, giving A - B with
// cout_o=1 meaning no borrow.
// ---------------------------------------------------------------------------
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_fsm_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cntWidth(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_aShift;
    logic [WIDTH-1:0] r_bShift;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;
    logic [DIGIT-1:0] w_sliceSum;
    logic             w_sliceCout;
    logic [WIDTH-1:0] w_partialNext;
    logic             w_load;
    logic             w_lastDigit;
    logic [WIDTH-1:0] w_bCapture;
    logic             w_carryCapture;

    serial_adder_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (r_aShift[DIGIT-1:0]),
        .b    (r_bShift[DIGIT-1:0]),
        .cin  (r_carry),
        .s    (w_sliceSum),
        .cout (w_sliceCout)
    );

    // New sum digits enter at the MSB end so that after N shifts the first
    // digit computed has reached bit 0. With a single digit the slice output
    // is the whole result.
    generate
        if (DIGIT == WIDTH) begin : g_singleDigit
            assign w_partialNext = w_sliceSum;
        end else begin : g_multiDigit
            assign w_partialNext = {w_sliceSum, r_partial[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Subtraction is A + ~B + 1, so the operand inversion and forced carry
    // happen once at capture and the RUN datapath is identical for both.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_bCapture     = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign w_carryCapture = bus.sub_i ? 1'b1 : bus.cin_i;
`else
    assign w_bCapture     = bus.b_i;
    assign w_carryCapture = bus.cin_i;
`endif

    assign w_lastDigit = (r_state == RUN) && (r_count == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode. Start is only looked at in IDLE, so a start during
    // RUN or DONE is simply dropped.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_nextState = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (w_lastDigit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture on the accepted start, then one digit per RUN cycle.
    // The visible result registers move only on the last digit, so a later
    // operation never disturbs sum_o/cout_o until it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aShift  <= '0;
            r_bShift  <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_count   <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else if (w_load) begin
            r_aShift  <= bus.a_i;
            r_bShift  <= w_bCapture;
            r_partial <= '0;
            r_carry   <= w_carryCapture;
            r_count   <= '0;
        end else if (r_state == RUN) begin
            r_aShift  <= r_aShift >> DIGIT;
            r_bShift  <= r_bShift >> DIGIT;
            r_partial <= w_partialNext;
            r_carry   <= w_sliceCout;
            r_count   <= r_count + 1'b1;
            if (w_lastDigit) begin
                r_sum  <= w_partialNext;
                r_cout <= w_sliceCout;
            end
        end
    end

    assign bus.busy_o = (r_state == RUN);
    assign bus.done_o = (r_state == DONE);
    assign bus.sum_o  = r_sum;
    assign bus.cout_o = r_cout;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_fsm
//
// Purpose: self-checking bench for serial_adder_fsm. Three instances cover
// WIDTH=8/DIGIT=1, WIDTH=8/DIGIT=4 and WIDTH=16/DIGIT=16. Expected results
// come from a plain arithmetic model of (A + B + cin) or (A - B).
// Optional feature macro: SERIAL_ADDER_SUB_EN enables the subtract steps.
// ---------------------------------------------------------------------------
module tb_serial_adder_fsm;

    logic clk;
    logic rst_n;
    logic subReq;

    int testsRun;
    int testsFailed;

    logic [15:0] lastSum  [3];
    logic        lastCout [3];
    int          widthOf  [3];
    int          cyclesOf [3];

    serial_adder_fsm_if #(.WIDTH(8))  if8a ();
    serial_adder_fsm_if #(.WIDTH(8))  if8b ();
    serial_adder_fsm_if #(.WIDTH(16)) if16 ();

`ifdef SERIAL_ADDER_SUB_EN
    assign if8a.sub_i = subReq;
    assign if8b.sub_i = subReq;
    assign if16.sub_i = subReq;
`endif

    serial_adder_fsm #(.WIDTH(8), .DIGIT(1)) dut8x1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8a)
    );

    serial_adder_fsm #(.WIDTH(8), .DIGIT(4)) dut8x4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8b)
    );

    serial_adder_fsm #(.WIDTH(16), .DIGIT(16)) dut16x16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts the failure and
    // reports the tag with observed and expected values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the request side of one instance.
    task automatic driveIn(input int cfg, input logic start, input logic [15:0] a,
                           input logic [15:0] b, input logic cin);
        case (cfg)
            0: begin
                if8a.start_i = start; if8a.a_i = a[7:0]; if8a.b_i = b[7:0]; if8a.cin_i = cin;
            end
            1: begin
                if8b.start_i = start; if8b.a_i = a[7:0]; if8b.b_i = b[7:0]; if8b.cin_i = cin;
            end
            default: begin
                if16.start_i = start; if16.a_i = a; if16.b_i = b; if16.cin_i = cin;
            end
        endcase
    endtask

    // Read the response side of one instance, sum zero-extended to 16 bits.
    task automatic sampleOut(input int cfg, output logic busy, output logic done,
                             output logic [15:0] sum, output logic cout);
        case (cfg)
            0: begin
                busy = if8a.busy_o; done = if8a.done_o; sum = {8'h00, if8a.sum_o}; cout = if8a.cout_o;
            end
            1: begin
                busy = if8b.busy_o; done = if8b.done_o; sum = {8'h00, if8b.sum_o}; cout = if8b.cout_o;
            end
            default: begin
                busy = if16.busy_o; done = if16.done_o; sum = if16.sum_o; cout = if16.cout_o;
            end
        endcase
    endtask

    // Reference: plain integer arithmetic. Returns {cout, sum[15:0]}.
    function automatic logic [16:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin,
                                          input logic sub);
        longint unsigned modulus;
        longint unsigned full;
        logic [16:0]     res;
        modulus = 64'd1 << w;
        res     = '0;
        if (sub) begin
            full      = (longint'(a) + modulus - longint'(b)) % modulus;
            res[15:0] = full[15:0];
            res[16]   = (a >= b);
        end else begin
            full      = longint'(a) + longint'(b) + longint'(cin);
            res[15:0] = 16'(full % modulus);
            res[16]   = (full >= modulus);
        end
        return res;
    endfunction

    // Run one operation on instance cfg and check the handshake and result.
    // With injectStart, a second start is raised during RUN and must be
    // ignored.
    task automatic applyStimulus(input int cfg, input logic [15:0] aIn,
                                 input logic [15:0] bIn, input logic cin,
                                 input bit injectStart, input string tag);
        logic [15:0] mask;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] expected;
        logic        busy;
        logic        done;
        logic [15:0] sum;
        logic        cout;
        int          busyCycles;
        bit          doneSeen;
        mask     = (widthOf[cfg] == 16) ? 16'hFFFF : 16'h00FF;
        a        = aIn & mask;
        b        = bIn & mask;
        expected = model(widthOf[cfg], a, b, cin, subReq);

        @(negedge clk);
        driveIn(cfg, 1'b1, a, b, cin);
        @(negedge clk);
        driveIn(cfg, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));

        busyCycles = 0;
        doneSeen   = 1'b0;
        for (int cyc = 0; cyc < 40 && !doneSeen; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
            end
            sampleOut(cfg, busy, done, sum, cout);
            if (busy) begin
                busyCycles++;
                checkOutput({tag, " sum held during run"}, 32'(sum), 32'(lastSum[cfg]));
                checkOutput({tag, " cout held during run"}, 32'(cout), 32'(lastCout[cfg]));
                if (injectStart && busyCycles == 2) begin
                    driveIn(cfg, 1'b1, 16'h00AA, 16'h0055, 1'b0);
                end else if (injectStart && busyCycles == 3) begin
                    driveIn(cfg, 1'b0, 16'h0000, 16'h0000, 1'b0);
                end
            end
            if (done) begin
                doneSeen = 1'b1;
                checkOutput({tag, " busy low while done"}, 32'(busy), 32'd0);
            end
        end

        checkOutput({tag, " done seen"}, 32'(doneSeen), 32'd1);
        checkOutput({tag, " busy cycles"}, busyCycles, cyclesOf[cfg]);
        checkOutput({tag, " sum"}, 32'(sum), 32'(expected[15:0]));
        checkOutput({tag, " cout"}, 32'(cout), 32'(expected[16]));
        lastSum[cfg]  = expected[15:0];
        lastCout[cfg] = expected[16];

        // done must be a single pulse and the instance must fall back to idle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sampleOut(cfg, busy, done, sum, cout);
            checkOutput({tag, " done single pulse"}, 32'(done), 32'd0);
            checkOutput({tag, " idle after done"}, 32'(busy), 32'd0);
            checkOutput({tag, " sum stable after done"}, 32'(sum), 32'(expected[15:0]));
        end
    endtask

    initial begin
        logic        busy;
        logic        done;
        logic [15:0] sum;
        logic        cout;

        testsRun    = 0;
        testsFailed = 0;
        subReq      = 1'b0;
        widthOf     = '{8, 8, 16};
        cyclesOf    = '{8, 2, 1};
        for (int c = 0; c < 3; c++) begin
            lastSum[c]  = 16'h0000;
            lastCout[c] = 1'b0;
            driveIn(c, 1'b0, 16'h0000, 16'h0000, 1'b0);
        end

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            sampleOut(c, busy, done, sum, cout);
            checkOutput("reset busy", 32'(busy), 32'd0);
            checkOutput("reset done", 32'(done), 32'd0);
            checkOutput("reset sum", 32'(sum), 32'd0);
            checkOutput("reset cout", 32'(cout), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed WIDTH=8, DIGIT=1 cases.
        applyStimulus(0, 16'h003C, 16'h0055, 1'b0, 1'b0, "8x1 3C+55");
        applyStimulus(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, "8x1 FF+01");
        applyStimulus(0, 16'h00FF, 16'h0000, 1'b1, 1'b0, "8x1 FF+00+1");
        applyStimulus(0, 16'h0001, 16'h0001, 1'b0, 1'b1, "8x1 ignored start");

        // Reset in the middle of a run discards the operation.
        @(negedge clk);
        driveIn(0, 1'b1, 16'h0037, 16'h0011, 1'b0);
        @(negedge clk);
        driveIn(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        sampleOut(0, busy, done, sum, cout);
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        sampleOut(0, busy, done, sum, cout);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset sum", 32'(sum), 32'd0);
        checkOutput("async reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            lastSum[c]  = 16'h0000;
            lastCout[c] = 1'b0;
        end
        applyStimulus(0, 16'h0010, 16'h0020, 1'b0, 1'b0, "8x1 after reset 10+20");

        // Other digit widths.
        applyStimulus(1, 16'h009F, 16'h0071, 1'b0, 1'b0, "8x4 9F+71");
        applyStimulus(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "16x16 FFFF+0001");

        // Randomized additions on every instance.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(c, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "random add");
            end
        end

`ifdef SERIAL_ADDER_SUB_EN
        subReq = 1'b1;
        applyStimulus(0, 16'h0010, 16'h0001, 1'b1, 1'b0, "8x1 sub 10-01");
        applyStimulus(0, 16'h0001, 16'h0002, 1'b0, 1'b0, "8x1 sub 01-02");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(c, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "random sub");
            end
        end
        subReq = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
